arp_lut_reg_ctrl: RTL and testbench
===================================

ARP_LUT_REG_CTRL -- requirements
Module: arp_lut_reg_ctrl

Interface
REQ-001 Parameter LUT_DEPTH_BITS, default 5, SHALL set the table address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for a table ack (range 1-255).
REQ-003 clk  input  1  SHALL be the clock; all logic is rising-edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 reg_req  input  1  SHALL be a single-cycle register access pulse.
REQ-006 reg_rd_wr_L  input  1  SHALL select the access type: 1 = read, 0 = write.
REQ-007 reg_addr  input  3  SHALL be the register word offset.
REQ-008 reg_wr_data  input  32  SHALL be the register write data.
REQ-009 reg_ack  output  1  SHALL be a single-cycle access-complete pulse.
REQ-010 reg_rd_data  output  32  SHALL be the read data, valid while reg_ack=1.
REQ-011 arp_rd_addr  output  LUT_DEPTH_BITS  SHALL be the table read index.
REQ-012 arp_rd_req  output  1  SHALL be the table read request.
REQ-013 arp_rd_mac  input  48  SHALL be the MAC returned by the table.
REQ-014 arp_rd_ip  input  32  SHALL be the IP returned by the table.
REQ-015 arp_rd_ack  input  1  SHALL be the table read-done pulse.
REQ-016 arp_wr_addr  output  LUT_DEPTH_BITS  SHALL be the table write index.
REQ-017 arp_wr_req  output  1  SHALL be the table write request.
REQ-018 arp_wr_mac  output  48  SHALL be the MAC to write into the table.
REQ-019 arp_wr_ip  output  32  SHALL be the IP to write into the table.
REQ-020 arp_wr_ack  input  1  SHALL be the table write-done pulse.

Function
REQ-021 Register map SHALL be as follows. 0 MAC_HI: bits[15:0] = staged mac[47:32], upper bits read 0. 1 MAC_LO: staged mac[31:0]. 2 IP: staged IP. 3 RD_ADDR: writing triggers a table read. 4 WR_ADDR: writing triggers a table write. 5 STATUS. Offsets 6 and 7 read 0 and ignore writes.
REQ-022 The FSM SHALL have the states IDLE, RD_WAIT, WR_WAIT and ACK; a reg_req SHALL be accepted only in IDLE.
REQ-023 Plain accesses (all offsets except a write to 3 or 4) SHALL update the registers and assert reg_ack exactly 1 cycle after reg_req.
REQ-024 A write to offset 3 SHALL latch arp_rd_addr = reg_wr_data[LUT_DEPTH_BITS-1:0], ignoring the upper bits, and then enter RD_WAIT.
REQ-025 arp_rd_req SHALL be high from the cycle after reg_req until the cycle in which arp_rd_ack is sampled high.
REQ-026 On arp_rd_ack, the staging MAC/IP SHALL load from arp_rd_mac/arp_rd_ip; the FSM SHALL go to ACK; reg_ack SHALL pulse in the next cycle.
REQ-027 A write to offset 4 SHALL latch arp_wr_addr from reg_wr_data[LUT_DEPTH_BITS-1:0] and then enter WR_WAIT.
REQ-028 In WR_WAIT, arp_wr_req SHALL be held high, with arp_wr_mac/arp_wr_ip driven from the staging registers, until arp_wr_ack.
REQ-029 Each completed table write SHALL increment an 8-bit write counter, which wraps from 255 to 0.
REQ-030 A wait counter SHALL start at 0 on entry to RD_WAIT/WR_WAIT and count up each cycle.
REQ-031 On reaching TIMEOUT without an ack, the block SHALL drop the request, leave staging unchanged, set STATUS bit0 (sticky), go to ACK and pulse reg_ack.
REQ-032 If an ack and timeout expiry coincide, the ack SHALL win: the operation completes normally and bit0 is not set.
REQ-033 A reg_req arriving outside IDLE SHALL be dropped without an ack and SHALL set STATUS bit1 (sticky).
REQ-034 STATUS SHALL read as: bit0 timeout, bit1 dropped request, bit2 busy (state != IDLE), bits[15:8] write counter, all other bits 0.
REQ-035 Writing STATUS SHALL clear bit0 and/or bit1 where the corresponding write-data bit = 1; the counter is unaffected.
REQ-036 An arp_rd_ack or arp_wr_ack received outside the matching wait state SHALL be ignored.
REQ-037 ACK SHALL last exactly 1 cycle and then return to IDLE; the earliest next accepted reg_req is the cycle after reg_ack.
REQ-038 reg_rd_data SHALL be 0 whenever reg_ack=0 and whenever a write is acknowledged.

Reset
REQ-039 On reset, all outputs, staging registers, STATUS bits and counters SHALL be 0, and the state SHALL be IDLE.
REQ-040 Reset asserted mid-operation SHALL abandon the operation: the request deasserts the cycle after reset is sampled, and no reg_ack is issued.

Verification
REQ-041 Write MAC_HI=0x0000_0011, MAC_LO=0x2233_4455, IP=0x0A00_0001, then WR_ADDR=3, with arp_wr_ack 4 cycles later. Required: arp_wr_mac=0x112233445566-style staged value 0x0011_2233_4455, arp_wr_ip=0x0A000001, arp_wr_addr=3, reg_ack 1 cycle after the ack, STATUS[15:8]=1.
REQ-042 Write RD_ADDR=0x25, table returns mac 0xAABBCCDDEEFF, ip 0xC0A80101 with ack after 2 cycles. Required: arp_rd_addr=5, then MAC_HI reads 0xAABB, MAC_LO reads 0xCCDDEEFF, IP reads 0xC0A80101.
REQ-043 With TIMEOUT=8, write WR_ADDR and never ack. Required: arp_wr_req drops after 8 cycles, reg_ack pulses, STATUS reads 0x1 (bit0); writing STATUS=1 then reads 0.
REQ-044 Issue reg_req during RD_WAIT. Required: no extra reg_ack, STATUS bit1=1, the table read still completes normally.
REQ-045 Perform 256 table writes. Required: STATUS[15:8]=0 after wrap. Then assert reset during WR_WAIT. Required: arp_wr_req=0 next cycle, all registers read 0.

Source files
------------

// File: rtl/arp_lut_reg_ctrl_if.sv
// Register-bus and ARP table port bundle for arp_lut_reg_ctrl.
// slave is the controller side; master is the host/table side.
interface arp_lut_reg_ctrl_if #(
    parameter int unsigned LUT_DEPTH_BITS = 5
);
    logic                      reg_req;
    logic                      reg_rd_wr_L;
    logic [2:0]                reg_addr;
    logic [31:0]               reg_wr_data;
    logic                      reg_ack;
    logic [31:0]               reg_rd_data;

    logic [LUT_DEPTH_BITS-1:0] arp_rd_addr;
    logic                      arp_rd_req;
    logic [47:0]               arp_rd_mac;
    logic [31:0]               arp_rd_ip;
    logic                      arp_rd_ack;

    logic [LUT_DEPTH_BITS-1:0] arp_wr_addr;
    logic                      arp_wr_req;
    logic [47:0]               arp_wr_mac;
    logic [31:0]               arp_wr_ip;
    logic                      arp_wr_ack;

    modport slave (
        input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        output reg_ack, reg_rd_data,
        output arp_rd_addr, arp_rd_req,
        input  arp_rd_mac, arp_rd_ip, arp_rd_ack,
        output arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip,
        input  arp_wr_ack
    );

    modport master (
        output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        input  reg_ack, reg_rd_data,
        input  arp_rd_addr, arp_rd_req,
        output arp_rd_mac, arp_rd_ip, arp_rd_ack,
        input  arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip,
        output arp_wr_ack
    );
endinterface

// File: rtl/arp_lut_reg_ctrl.sv
// Register front-end for the ARP lookup table: stages MAC/IP words and
// turns RD_ADDR/WR_ADDR writes into timed table read/write handshakes.
module arp_lut_reg_ctrl #(
    parameter int unsigned LUT_DEPTH_BITS = 5,
    parameter int unsigned TIMEOUT        = 255
) (
    input logic             clk,
    input logic             reset,
    arp_lut_reg_ctrl_if.slave bus
);
    localparam int unsigned AW     = LUT_DEPTH_BITS;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] A_MAC_HI  = 3'd0;
    localparam logic [2:0] A_MAC_LO  = 3'd1;
    localparam logic [2:0] A_IP      = 3'd2;
    localparam logic [2:0] A_RD_ADDR = 3'd3;
    localparam logic [2:0] A_WR_ADDR = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_ACK
    } state_t;

    state_t           state;
    logic [47:0]      mac_stage;
    logic [31:0]      ip_stage;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             st_timeout;
    logic             st_drop;
    logic [31:0]      rd_mux;
    logic [AW-1:0]    addr_in;

    assign addr_in        = bus.reg_wr_data[AW-1:0];
    assign bus.arp_wr_mac = mac_stage;
    assign bus.arp_wr_ip  = ip_stage;

    // Register read mux
    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            A_MAC_HI:  rd_mux = {16'h0000, mac_stage[47:32]};
            A_MAC_LO:  rd_mux = mac_stage[31:0];
            A_IP:      rd_mux = ip_stage;
            A_RD_ADDR: rd_mux = 32'(bus.arp_rd_addr);
            A_WR_ADDR: rd_mux = 32'(bus.arp_wr_addr);
            A_STATUS:  rd_mux = {16'h0000, wr_cnt, 5'b00000,
                                 (state != S_IDLE), st_drop, st_timeout};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            mac_stage       <= '0;
            ip_stage        <= '0;
            wr_cnt          <= '0;
            wait_cnt        <= '0;
            st_timeout      <= 1'b0;
            st_drop         <= 1'b0;
            bus.reg_ack     <= 1'b0;
            bus.reg_rd_data <= '0;
            bus.arp_rd_addr <= '0;
            bus.arp_rd_req  <= 1'b0;
            bus.arp_wr_addr <= '0;
            bus.arp_wr_req  <= 1'b0;
        end else begin
            bus.reg_ack     <= 1'b0;
            bus.reg_rd_data <= '0;

            unique case (state)
                S_IDLE: begin
                    if (bus.reg_req) begin
                        if (bus.reg_rd_wr_L) begin
                            bus.reg_rd_data <= rd_mux;
                            bus.reg_ack     <= 1'b1;
                            state           <= S_ACK;
                        end else if (bus.reg_addr == A_RD_ADDR) begin
                            bus.arp_rd_addr <= addr_in;
                            bus.arp_rd_req  <= 1'b1;
                            wait_cnt        <= '0;
                            state           <= S_RD_WAIT;
                        end else if (bus.reg_addr == A_WR_ADDR) begin
                            bus.arp_wr_addr <= addr_in;
                            bus.arp_wr_req  <= 1'b1;
                            wait_cnt        <= '0;
                            state           <= S_WR_WAIT;
                        end else begin
                            case (bus.reg_addr)
                                A_MAC_HI: mac_stage[47:32] <= bus.reg_wr_data[15:0];
                                A_MAC_LO: mac_stage[31:0]  <= bus.reg_wr_data;
                                A_IP:     ip_stage         <= bus.reg_wr_data;
                                A_STATUS: begin
                                    if (bus.reg_wr_data[0]) st_timeout <= 1'b0;
                                    if (bus.reg_wr_data[1]) st_drop    <= 1'b0;
                                end
                                default: ;
                            endcase
                            bus.reg_ack <= 1'b1;
                            state       <= S_ACK;
                        end
                    end
                end

                // Ack is tested before expiry so a coincident ack completes normally
                S_RD_WAIT: begin
                    if (bus.arp_rd_ack) begin
                        mac_stage      <= bus.arp_rd_mac;
                        ip_stage       <= bus.arp_rd_ip;
                        bus.arp_rd_req <= 1'b0;
                        bus.reg_ack    <= 1'b1;
                        state          <= S_ACK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        st_timeout     <= 1'b1;
                        bus.arp_rd_req <= 1'b0;
                        bus.reg_ack    <= 1'b1;
                        state          <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_WR_WAIT: begin
                    if (bus.arp_wr_ack) begin
                        wr_cnt         <= wr_cnt + CNT_W'(1);
                        bus.arp_wr_req <= 1'b0;
                        bus.reg_ack    <= 1'b1;
                        state          <= S_ACK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        st_timeout     <= 1'b1;
                        bus.arp_wr_req <= 1'b0;
                        bus.reg_ack    <= 1'b1;
                        state          <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_ACK: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase

            // Requests arriving while busy are dropped and flagged
            if (bus.reg_req && (state != S_IDLE)) st_drop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_arp_lut_reg_ctrl.sv
// Scoreboard bench for arp_lut_reg_ctrl: stimulus queues expected read data,
// a negedge monitor pops and compares on every reg_ack.
module tb_arp_lut_reg_ctrl;
    localparam int unsigned AW = 5;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arp_lut_reg_ctrl_if #(.LUT_DEPTH_BITS(AW)) bus ();

    arp_lut_reg_ctrl #(.LUT_DEPTH_BITS(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int ack_seen = 0;
    int ack_exp  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every reg_ack must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.reg_ack === 1'b1) begin
                ack_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: reg_ack=1 with no outstanding access, reg_rd_data=0x%0h at %0t",
                             bus.reg_rd_data, $time);
                end else begin
                    check("reg_rd_data", 64'(bus.reg_rd_data), 64'(exp_q.pop_front()));
                end
            end else begin
                check("rd_data_idle_zero", 64'(bus.reg_rd_data), 64'd0);
            end
        end
    end

    task automatic expect_ack(input logic [31:0] e);
        exp_q.push_back(e);
        ack_exp++;
    endtask

    task automatic do_req(input bit rd, input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.reg_req     = 1'b1;
        bus.reg_rd_wr_L = rd;
        bus.reg_addr    = a;
        bus.reg_wr_data = d;
        @(posedge clk); #1;
        bus.reg_req     = 1'b0;
        bus.reg_wr_data = '0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_seen < ack_exp && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ack_count", 64'(ack_seen), 64'(ack_exp));
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        expect_ack(32'h0);
        do_req(1'b0, a, d);
        wait_ack();
    endtask

    task automatic reg_rd(input logic [2:0] a, input logic [31:0] e);
        expect_ack(e);
        do_req(1'b1, a, 32'h0);
        wait_ack();
    endtask

    // Pulse a table ack so that it is sampled 'delay' edges after the trigger edge
    task automatic table_ack(input bit wr, input int delay);
        repeat (delay - 1) begin
            @(posedge clk); #1;
        end
        if (wr) bus.arp_wr_ack = 1'b1;
        else    bus.arp_rd_ack = 1'b1;
        @(posedge clk); #1;
        bus.arp_wr_ack = 1'b0;
        bus.arp_rd_ack = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        bus.reg_req     = 1'b0;
        bus.reg_rd_wr_L = 1'b0;
        bus.reg_addr    = '0;
        bus.reg_wr_data = '0;
        bus.arp_rd_mac  = '0;
        bus.arp_rd_ip   = '0;
        bus.arp_rd_ack  = 1'b0;
        bus.arp_wr_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_ack",    64'(bus.reg_ack),     64'd0);
        check("rst_arp_rd_req", 64'(bus.arp_rd_req),  64'd0);
        check("rst_arp_wr_req", 64'(bus.arp_wr_req),  64'd0);
        check("rst_arp_wr_mac", 64'(bus.arp_wr_mac),  64'd0);
        check("rst_arp_rd_addr", 64'(bus.arp_rd_addr), 64'd0);
        reset = 1'b0;
        reg_rd(3'd5, 32'h0000_0000);
        reg_rd(3'd0, 32'h0000_0000);

        // Staged table write acked 4 cycles after the trigger
        reg_wr(3'd0, 32'hDEAD_0011);
        reg_wr(3'd1, 32'h2233_4455);
        reg_wr(3'd2, 32'h0A00_0001);
        reg_rd(3'd0, 32'h0000_0011);
        expect_ack(32'h0);
        do_req(1'b0, 3'd4, 32'hFFFF_FFE3);
        check("wr_req_high",  64'(bus.arp_wr_req),  64'd1);
        check("wr_addr",      64'(bus.arp_wr_addr), 64'd3);
        check("wr_mac",       64'(bus.arp_wr_mac),  64'h0011_2233_4455);
        check("wr_ip",        64'(bus.arp_wr_ip),   64'h0A00_0001);
        table_ack(1'b1, 4);
        check("wr_req_done",  64'(bus.arp_wr_req),  64'd0);
        check("wr_reg_ack",   64'(bus.reg_ack),     64'd1);
        wait_ack();
        reg_rd(3'd5, 32'h0000_0100);
        reg_rd(3'd1, 32'h2233_4455);

        // Table read with address truncation
        expect_ack(32'h0);
        do_req(1'b0, 3'd3, 32'h0000_0025);
        check("rd_addr",     64'(bus.arp_rd_addr), 64'd5);
        check("rd_req_high", 64'(bus.arp_rd_req),  64'd1);
        bus.arp_rd_mac = 48'hAABB_CCDD_EEFF;
        bus.arp_rd_ip  = 32'hC0A8_0101;
        table_ack(1'b0, 2);
        check("rd_req_done", 64'(bus.arp_rd_req),  64'd0);
        wait_ack();
        reg_rd(3'd0, 32'h0000_AABB);
        reg_rd(3'd1, 32'hCCDD_EEFF);
        reg_rd(3'd2, 32'hC0A8_0101);
        reg_rd(3'd6, 32'h0000_0000);
        reg_wr(3'd7, 32'hFFFF_FFFF);
        reg_rd(3'd7, 32'h0000_0000);

        // Write timeout: request held exactly TO cycles
        expect_ack(32'h0);
        do_req(1'b0, 3'd4, 32'h0000_0001);
        check("to_wr_mac", 64'(bus.arp_wr_mac), 64'hAABB_CCDD_EEFF);
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("to_req_last_cycle", 64'(bus.arp_wr_req), 64'd1);
        @(posedge clk); #1;
        check("to_req_dropped", 64'(bus.arp_wr_req), 64'd0);
        check("to_reg_ack",     64'(bus.reg_ack),    64'd1);
        wait_ack();
        reg_rd(3'd5, 32'h0000_0101);
        reg_rd(3'd1, 32'hCCDD_EEFF);
        reg_wr(3'd5, 32'h0000_0001);
        reg_rd(3'd5, 32'h0000_0100);

        // Request during RD_WAIT is dropped; read still completes
        expect_ack(32'h0);
        do_req(1'b0, 3'd3, 32'h0000_0007);
        do_req(1'b1, 3'd5, 32'h0);
        bus.arp_rd_mac = 48'h0102_0304_0506;
        bus.arp_rd_ip  = 32'h0708_090A;
        table_ack(1'b0, 2);
        wait_ack();
        reg_rd(3'd5, 32'h0000_0102);
        reg_rd(3'd0, 32'h0000_0102);
        reg_rd(3'd2, 32'h0708_090A);
        reg_wr(3'd5, 32'hFFFF_FF02);
        reg_rd(3'd5, 32'h0000_0100);

        // Stray table acks in IDLE are ignored
        bus.arp_rd_mac = 48'hFFFF_FFFF_FFFF;
        bus.arp_rd_ip  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.arp_rd_ack = 1'b1;
        bus.arp_wr_ack = 1'b1;
        @(posedge clk); #1;
        bus.arp_rd_ack = 1'b0;
        bus.arp_wr_ack = 1'b0;
        reg_rd(3'd1, 32'h0304_0506);
        reg_rd(3'd5, 32'h0000_0100);

        // Ack on the final wait cycle beats the timeout
        expect_ack(32'h0);
        do_req(1'b0, 3'd4, 32'h0000_0002);
        table_ack(1'b1, 8);
        check("coinc_req_done", 64'(bus.arp_wr_req), 64'd0);
        wait_ack();
        reg_rd(3'd5, 32'h0000_0200);

        // Write counter wraps 255 -> 0
        for (int i = 0; i < 253; i++) begin
            expect_ack(32'h0);
            do_req(1'b0, 3'd4, 32'(i));
            table_ack(1'b1, 1);
            wait_ack();
        end
        reg_rd(3'd5, 32'h0000_FF00);
        expect_ack(32'h0);
        do_req(1'b0, 3'd4, 32'h0000_000A);
        table_ack(1'b1, 1);
        wait_ack();
        reg_rd(3'd5, 32'h0000_0000);

        // Reset in WR_WAIT abandons the write without an ack
        reg_wr(3'd1, 32'h1234_5678);
        do_req(1'b0, 3'd4, 32'h0000_0009);
        check("rst_pre_req",  64'(bus.arp_wr_req),  64'd1);
        check("rst_pre_addr", 64'(bus.arp_wr_addr), 64'd9);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_req",  64'(bus.arp_wr_req),  64'd0);
        check("rst_mid_ack",  64'(bus.reg_ack),     64'd0);
        check("rst_mid_addr", 64'(bus.arp_wr_addr), 64'd0);
        check("rst_mid_mac",  64'(bus.arp_wr_mac),  64'd0);
        reset = 1'b0;
        for (int a = 0; a < 6; a++) reg_rd(3'(a), 32'h0);

        repeat (4) @(posedge clk);
        #1;
        check("pending_expects", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
